// File: rtl/pdc_pkg.sv
// pdc_pkg: shared types and elaboration helpers for the pdc_frame generator.
// Exports the FSM state enum, down-counter width helpers and parameter check.
package pdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        VLEAD,
        LINE,
        HBLANK,
        TAIL
    } pdc_state_t;

    function automatic int max_of5(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Width of a down-counter that holds values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int dw, input int aw,
                                     input int hb, input int vl,
                                     input int vsl, input int ll,
                                     input int hbl, input int ft,
                                     input int rl);
        return (dw >= 1) && (aw >= 1) && (hb >= 1) && (vl >= 1) &&
               (vsl >= 1) && (ll >= 1) && (hbl >= 0) && (ft >= 1) &&
               (rl >= 1) && (rl <= ll) && (rl <= hbl + 1) &&
               (longint'(vl) * longint'(hb) <= (longint'(1) << aw));
    endfunction

endpackage

// File: rtl/pdc_frame_if.sv
// pdc_frame_if: read bus between the frame generator and the pixel buffer.
// master: dataReadReq/index out, data in.  slave: the buffer side.
interface pdc_frame_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              dataReadReq;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;

    modport master (output dataReadReq, output index, input data);
    modport slave  (input dataReadReq, input index, output data);
endinterface

// File: rtl/pdc_fetch_gen.sv
// pdc_fetch_gen: buffer read request and address generator.
// Ports: clk/res, pre_pix (pixel due RD_LAT later), frame_go, rd_req, rd_addr.
module pdc_fetch_gen #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              res,
    input  logic              pre_pix,
    input  logic              frame_go,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr
);
    // Lines are fetched back to back, so line*H_BYTES+col is a single
    // running address cleared only at frame start.
    logic [ADDR_W-1:0] addr;

    always_ff @(negedge clk or posedge res) begin
        if (res) begin
            addr <= '0;
        end else if (frame_go) begin
            addr <= '0;
        end else if (pre_pix) begin
            addr <= addr + 1'b1;
        end
    end

    assign rd_req  = pre_pix;
    assign rd_addr = addr;
endmodule

// File: rtl/pdc_frame.sv
// pdc_frame: multi-line parallel-camera frame generator (VSYNC/HSYNC/PIXD).
// Ports: clk, res, output_ON, cont_mode, bus (buffer read), busy, frame_done,
// VSYNC, HSYNC, PIXCLK, PIXD. State updates on the falling clock edge.
module pdc_frame
    import pdc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 12,
    parameter int H_BYTES    = 4,
    parameter int V_LINES    = 1,
    parameter int VSYNC_LEAD = 128,
    parameter int LINE_LEAD  = 9,
    parameter int H_BLANK    = 3,
    parameter int FRAME_TAIL = 10,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              output_ON,
    input  logic              cont_mode,
    pdc_frame_if.master       bus,
    output logic              busy,
    output logic              frame_done,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic              PIXCLK,
    output logic [DATA_W-1:0] PIXD
);
    if (!params_ok(DATA_W, ADDR_W, H_BYTES, V_LINES, VSYNC_LEAD,
                   LINE_LEAD, H_BLANK, FRAME_TAIL, RD_LAT)) begin : g_bad
        $error("pdc_frame: illegal parameter set");
    end

    localparam int CW = cnt_w(max_of5(VSYNC_LEAD, LINE_LEAD, H_BYTES,
                                      H_BLANK, FRAME_TAIL));
    localparam int LW = cnt_w(V_LINES);

    localparam logic [CW-1:0] VSL_M1 = CW'(VSYNC_LEAD - 1);
    localparam logic [CW-1:0] LL_M1  = CW'(LINE_LEAD - 1);
    localparam logic [CW-1:0] HB_M1  = CW'(H_BYTES - 1);
    localparam logic [CW-1:0] HBL_M1 = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] FT_M1  = CW'(FRAME_TAIL - 1);
    localparam logic [LW-1:0] LN_MAX = LW'(V_LINES - 1);

    pdc_state_t    state, nxt;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [LW-1:0] ln, nxt_ln;
    logic          cont_q, nxt_cont;
    logic          on_q;
    logic          go, done_d, last, pre_pix;
    logic          rd_req;
    logic [ADDR_W-1:0] rd_addr;
    int            cnt_i;

    assign last  = (ln == LN_MAX);
    assign cnt_i = int'(cnt);

    always_ff @(negedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            cnt        <= '0;
            ln         <= '0;
            cont_q     <= 1'b0;
            on_q       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= nxt_cnt;
            ln         <= nxt_ln;
            cont_q     <= nxt_cont;
            on_q       <= output_ON;
            frame_done <= done_d;
        end
    end

    always_comb begin
        nxt      = state;
        nxt_cnt  = cnt - 1'b1;
        nxt_ln   = ln;
        nxt_cont = cont_q;
        go       = 1'b0;
        done_d   = 1'b0;
        unique case (state)
            IDLE: begin
                nxt_cnt = cnt;
                // Start needs a fresh rising edge of output_ON.
                if (output_ON && !on_q) begin
                    nxt      = PRE;
                    nxt_cnt  = VSL_M1;
                    nxt_ln   = '0;
                    nxt_cont = cont_mode;
                    go       = 1'b1;
                end
            end
            PRE: if (cnt == '0) begin
                nxt     = VLEAD;
                nxt_cnt = LL_M1;
            end
            VLEAD: if (cnt == '0) begin
                nxt     = LINE;
                nxt_cnt = HB_M1;
            end
            LINE: if (cnt == '0) begin
                if (last) begin
                    nxt     = TAIL;
                    nxt_cnt = FT_M1;
                end else begin
                    nxt_ln = ln + 1'b1;
                    if (H_BLANK == 0) begin
                        nxt     = LINE;
                        nxt_cnt = HB_M1;
                    end else begin
                        nxt     = HBLANK;
                        nxt_cnt = HBL_M1;
                    end
                end
            end
            HBLANK: if (cnt == '0) begin
                nxt     = LINE;
                nxt_cnt = HB_M1;
            end
            TAIL: if (cnt == '0) begin
                done_d = 1'b1;
                if (cont_q && output_ON) begin
                    nxt      = PRE;
                    nxt_cnt  = VSL_M1;
                    nxt_ln   = '0;
                    nxt_cont = cont_mode;
                    go       = 1'b1;
                end else begin
                    nxt     = IDLE;
                    nxt_cnt = '0;
                end
            end
            default: begin
                nxt     = IDLE;
                nxt_cnt = '0;
            end
        endcase
    end

    // High when a pixel is shown RD_LAT cycles from now. cnt+1 is the
    // number of cycles left in the current state; RD_LAT <= H_BLANK+1
    // keeps the look-ahead within the next line.
    always_comb begin
        pre_pix = 1'b0;
        unique case (state)
            VLEAD:   pre_pix = (cnt_i < RD_LAT);
            LINE:    pre_pix = (cnt_i >= RD_LAT) ||
                               (!last && (cnt_i + 1 + H_BLANK <= RD_LAT));
            HBLANK:  pre_pix = (cnt_i < RD_LAT) &&
                               (cnt_i + 1 + H_BYTES > RD_LAT);
            default: pre_pix = 1'b0;
        endcase
    end

    pdc_fetch_gen #(
        .ADDR_W(ADDR_W)
    ) u_fetch (
        .clk     (clk),
        .res     (res),
        .pre_pix (pre_pix),
        .frame_go(go),
        .rd_req  (rd_req),
        .rd_addr (rd_addr)
    );

    assign bus.dataReadReq = rd_req;
    assign bus.index       = rd_addr;

    assign busy   = (state != IDLE);
    assign VSYNC  = (state != IDLE) && (state != PRE);
    assign HSYNC  = (state == LINE);
    assign PIXCLK = clk;
    assign PIXD   = HSYNC ? bus.data : '0;
endmodule
